alt_vipvfr131_common_timing_measure: RTL and testbench

Measures incoming video sync timing (samples per line, lines per frame, interlace, field order) and qualifies it as stable. Sits directly upstream of the sync generation stage in the clocked-video path. Supplies the totals, valid flags, `stable`, `start_of_vsync`, `field_prediction` and `interlaced` that the sync generation stage consumes.

---
 rtl/alt_vipvfr131_common_timing_measure.sv | 234 +++++++++++++++++++++++
 tb/tb_alt_vipvfr131_common_timing_measure.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alt_vipvfr131_common_timing_measure.sv
// Video sync timing measurement: samples per line, lines per frame and interlace
// detection, with match-count qualification of the measured totals.

module alt_vipvfr131_common_timing_measure_qual #(
    parameter int W                = 14,
    parameter int TOTALS_MINUS_ONE = 0,
    parameter int MATCH_THRESHOLD  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         capture_en,
    input  logic         clear,
    input  logic [W-1:0] capture,
    output logic [W-1:0] total,
    output logic         valid,
    output logic         change
);

    localparam logic [W-1:0] OFFSET    = W'(TOTALS_MINUS_ONE);
    localparam logic [3:0]   THRESHOLD = 4'(MATCH_THRESHOLD);

    logic [W-1:0] prev;
    logic [W-1:0] new_total;
    logic [3:0]   match;
    logic [3:0]   match_nxt;
    logic         valid_nxt;
    logic         had_valid;

    always_comb begin
        match_nxt = match;
        if (clear) begin
            match_nxt = '0;
        end else if (capture_en) begin
            if (capture == prev) begin
                match_nxt = (match == 4'hF) ? match : match + 4'd1;
            end else begin
                match_nxt = 4'd1;
            end
        end
        valid_nxt = (match_nxt >= THRESHOLD);
        new_total = capture - OFFSET;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev      <= '0;
            match     <= '0;
            valid     <= 1'b0;
            had_valid <= 1'b0;
            total     <= '0;
            change    <= 1'b0;
        end else if (!enable) begin
            prev      <= '0;
            match     <= '0;
            valid     <= 1'b0;
            had_valid <= 1'b0;
            total     <= '0;
            change    <= 1'b0;
        end else begin
            if (capture_en) begin
                prev <= capture;
            end
            match     <= match_nxt;
            valid     <= valid_nxt;
            had_valid <= had_valid | valid_nxt;
            if (valid_nxt && !valid) begin
                total <= new_total;
            end
            // A rise only counts as a change when it replaces an earlier, different total.
            change <= (valid && !valid_nxt) ||
                      (valid_nxt && !valid && had_valid && (new_total != total));
        end
    end

endmodule

module alt_vipvfr131_common_timing_measure #(
    parameter int TOTALS_MINUS_ONE = 0,
    parameter int MATCH_THRESHOLD  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sample_ce,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        field,
    output logic        start_of_vsync,
    output logic        field_prediction,
    output logic        interlaced,
    output logic [13:0] total_sample_count,
    output logic        total_sample_count_valid,
    output logic [12:0] total_line_count,
    output logic        total_line_count_valid,
    output logic        stable,
    output logic        resolution_change
);

    logic        hsync_r, hsync_d;
    logic        vsync_r, vsync_d;
    logic        field_r;
    logic        h_edge, v_edge;

    logic [13:0] sample_cnt;
    logic        h_lost, h_lost_nxt;

    logic [12:0] line_cnt;
    logic        last_field, prev_tog, tog;
    logic        interlaced_nxt, fp_nxt, frame_edge, mode_change;

    logic        sample_change, line_change;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync_r <= 1'b0;
            hsync_d <= 1'b0;
            vsync_r <= 1'b0;
            vsync_d <= 1'b0;
            field_r <= 1'b0;
        end else if (!enable) begin
            hsync_r <= 1'b0;
            hsync_d <= 1'b0;
            vsync_r <= 1'b0;
            vsync_d <= 1'b0;
            field_r <= 1'b0;
        end else begin
            hsync_r <= hsync;
            hsync_d <= hsync_r;
            vsync_r <= vsync;
            vsync_d <= vsync_r;
            field_r <= field;
        end
    end

    assign h_edge = hsync_r & ~hsync_d;
    assign v_edge = vsync_r & ~vsync_d;

    always_comb begin
        h_lost_nxt     = h_edge ? 1'b0 : (h_lost | (sample_cnt == '1));
        tog            = field_r ^ last_field;
        interlaced_nxt = interlaced;
        if (v_edge) begin
            if (tog && prev_tog) begin
                interlaced_nxt = 1'b1;
            end else if (!tog && !prev_tog) begin
                interlaced_nxt = 1'b0;
            end
        end
        fp_nxt      = interlaced & ~last_field;
        frame_edge  = v_edge & ~fp_nxt;
        mode_change = interlaced_nxt ^ interlaced;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt       <= '0;
            h_lost           <= 1'b0;
            line_cnt         <= '0;
            last_field       <= 1'b0;
            prev_tog         <= 1'b0;
            interlaced       <= 1'b0;
            field_prediction <= 1'b0;
            start_of_vsync   <= 1'b0;
        end else if (!enable) begin
            sample_cnt       <= '0;
            h_lost           <= 1'b0;
            line_cnt         <= '0;
            last_field       <= 1'b0;
            prev_tog         <= 1'b0;
            interlaced       <= 1'b0;
            field_prediction <= 1'b0;
            start_of_vsync   <= 1'b0;
        end else begin
            if (h_edge) begin
                sample_cnt <= {13'b0, sample_ce};
            end else if (sample_ce && (sample_cnt != '1)) begin
                sample_cnt <= sample_cnt + 14'd1;
            end
            h_lost <= h_lost_nxt;

            // An hsync coinciding with the frame boundary belongs to the new frame.
            if (frame_edge) begin
                line_cnt <= {12'b0, h_edge};
            end else if (h_edge && (line_cnt != '1)) begin
                line_cnt <= line_cnt + 13'd1;
            end

            start_of_vsync <= v_edge;
            if (v_edge) begin
                field_prediction <= fp_nxt;
                last_field       <= field_r;
                prev_tog         <= tog;
            end
            interlaced <= interlaced_nxt;
        end
    end

    alt_vipvfr131_common_timing_measure_qual #(
        .W                (14),
        .TOTALS_MINUS_ONE (TOTALS_MINUS_ONE),
        .MATCH_THRESHOLD  (MATCH_THRESHOLD)
    ) u_sample_qual (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .capture_en (h_edge),
        .clear      (h_lost_nxt),
        .capture    (sample_cnt),
        .total      (total_sample_count),
        .valid      (total_sample_count_valid),
        .change     (sample_change)
    );

    alt_vipvfr131_common_timing_measure_qual #(
        .W                (13),
        .TOTALS_MINUS_ONE (TOTALS_MINUS_ONE),
        .MATCH_THRESHOLD  (MATCH_THRESHOLD)
    ) u_line_qual (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .capture_en (frame_edge),
        .clear      (mode_change),
        .capture    (line_cnt),
        .total      (total_line_count),
        .valid      (total_line_count_valid),
        .change     (line_change)
    );

    assign stable            = total_sample_count_valid & total_line_count_valid & ~h_lost;
    assign resolution_change = sample_change | line_change;

endmodule

// File: tb/tb_alt_vipvfr131_common_timing_measure.sv
// Bench for alt_vipvfr131_common_timing_measure: two instances (totals and totals-1)
// driven by a scenario table, randomized timings and directed corner sequences.

module tb_alt_vipvfr131_common_timing_measure;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, enable, sample_ce, hsync, vsync, field;

    logic        sov_a, fp_a, intl_a, tscv_a, tlcv_a, stable_a, rc_a;
    logic [13:0] tsc_a;
    logic [12:0] tlc_a;
    logic        sov_b, fp_b, intl_b, tscv_b, tlcv_b, stable_b, rc_b;
    logic [13:0] tsc_b;
    logic [12:0] tlc_b;

    alt_vipvfr131_common_timing_measure #(
        .TOTALS_MINUS_ONE (0),
        .MATCH_THRESHOLD  (2)
    ) dut_a (
        .clk                      (clk),
        .rst                      (rst),
        .enable                   (enable),
        .sample_ce                (sample_ce),
        .hsync                    (hsync),
        .vsync                    (vsync),
        .field                    (field),
        .start_of_vsync           (sov_a),
        .field_prediction         (fp_a),
        .interlaced               (intl_a),
        .total_sample_count       (tsc_a),
        .total_sample_count_valid (tscv_a),
        .total_line_count         (tlc_a),
        .total_line_count_valid   (tlcv_a),
        .stable                   (stable_a),
        .resolution_change        (rc_a)
    );

    alt_vipvfr131_common_timing_measure #(
        .TOTALS_MINUS_ONE (1),
        .MATCH_THRESHOLD  (2)
    ) dut_b (
        .clk                      (clk),
        .rst                      (rst),
        .enable                   (enable),
        .sample_ce                (sample_ce),
        .hsync                    (hsync),
        .vsync                    (vsync),
        .field                    (field),
        .start_of_vsync           (sov_b),
        .field_prediction         (fp_b),
        .interlaced               (intl_b),
        .total_sample_count       (tsc_b),
        .total_sample_count_valid (tscv_b),
        .total_line_count         (tlc_b),
        .total_line_count_valid   (tlcv_b),
        .stable                   (stable_b),
        .resolution_change        (rc_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Event monitor on the falling edge (dut_a unless noted).
    int unsigned cyc = 0, last_sov = 0, sov_int = 0, last_rc = 0, rc_int = 0;
    int          sov_cnt = 0, rc_cnt = 0, rc_cnt_b = 0, s_low_cnt = 0;
    logic        fp_last = 1'b0, fp_prev = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sov_a) begin
            sov_cnt  <= sov_cnt + 1;
            sov_int  <= cyc - last_sov;
            last_sov <= cyc;
            fp_prev  <= fp_last;
            fp_last  <= fp_a;
        end
        if (rc_a) begin
            rc_cnt  <= rc_cnt + 1;
            rc_int  <= cyc - last_rc;
            last_rc <= cyc;
        end
        if (rc_b) rc_cnt_b <= rc_cnt_b + 1;
        if (!tscv_a) s_low_cnt <= s_low_cnt + 1;
    end

    task automatic tick(input logic h, input logic v, input logic f, input logic ce);
        hsync = h; vsync = v; field = f; sample_ce = ce;
        @(posedge clk); #1;
    endtask

    task automatic run_line(input int hp, input logic v, input logic f, input int ce_div);
        for (int c = 0; c < hp; c++)
            tick(c < 4, v, f, (ce_div == 1) ? 1'b1 : ((c % 2) == 1));
    endtask

    task automatic run_field(input int hp, input int nl, input logic f, input int ce_div);
        for (int l = 0; l < nl; l++) run_line(hp, l < 2, f, ce_div);
    endtask

    task automatic run_frames(input int hp, input int nl, input bit intl, input int nfr,
                              input int ce_div);
        for (int k = 0; k < nfr; k++) begin
            if (intl) begin
                run_field(hp, nl / 2, 1'b0, ce_div);
                run_field(hp, nl - nl / 2, 1'b1, ce_div);
            end else begin
                run_field(hp, nl, 1'b0, ce_div);
            end
        end
    endtask

    function automatic longint outs_a();
        return {sov_a, fp_a, intl_a, tsc_a, tscv_a, tlc_a, tlcv_a, stable_a, rc_a};
    endfunction

    function automatic longint outs_b();
        return {sov_b, fp_b, intl_b, tsc_b, tscv_b, tlc_b, tlcv_b, stable_b, rc_b};
    endfunction

    typedef struct {
        int hp;
        int nl;
        bit intl;
        int ce_div;
        int exp_s;
        int exp_l;
    } scen_t;

    localparam int NSCEN  = 10;
    localparam int NFRAME = 7;

    initial begin
        scen_t tbl[NSCEN];
        int    base_sov, base_rc, base_rcb, base_low;

        // Directed entries carry literal expectations; the rest come from the timing rules.
        tbl[0] = '{40, 10, 1'b0, 1, 40, 10};
        tbl[1] = '{32, 21, 1'b1, 1, 32, 21};
        tbl[2] = '{40, 12, 1'b0, 2, 20, 12};
        for (int i = 3; i < NSCEN; i++) begin
            tbl[i].hp     = 2 * int'($urandom_range(8, 16));
            tbl[i].nl     = int'($urandom_range(8, 14));
            tbl[i].intl   = bit'($urandom_range(0, 1));
            tbl[i].ce_div = int'($urandom_range(1, 2));
            tbl[i].exp_s  = tbl[i].hp / tbl[i].ce_div;
            tbl[i].exp_l  = tbl[i].nl;
        end

        rst = 1'b0; enable = 1'b1;
        hsync = 1'b0; vsync = 1'b0; field = 1'b0; sample_ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_a", outs_a(), 0);
        chk("reset_outputs_b", outs_b(), 0);
        rst = 1'b1;
        tick(0, 0, 0, 1);

        for (int i = 0; i < NSCEN; i++) begin
            base_sov = sov_cnt;
            run_frames(tbl[i].hp, tbl[i].nl, tbl[i].intl, NFRAME, tbl[i].ce_div);
            chk($sformatf("s%0d_samples_a", i), tsc_a, tbl[i].exp_s);
            chk($sformatf("s%0d_samples_b", i), tsc_b, tbl[i].exp_s - 1);
            chk($sformatf("s%0d_samples_valid", i), tscv_a, 1);
            chk($sformatf("s%0d_lines_a", i), tlc_a, tbl[i].exp_l);
            chk($sformatf("s%0d_lines_b", i), tlc_b, tbl[i].exp_l - 1);
            chk($sformatf("s%0d_lines_valid", i), tlcv_a, 1);
            chk($sformatf("s%0d_stable", i), stable_a, 1);
            chk($sformatf("s%0d_interlaced", i), intl_a, tbl[i].intl);
            chk($sformatf("s%0d_sov_count", i), sov_cnt - base_sov,
                tbl[i].intl ? 2 * NFRAME : NFRAME);
            chk($sformatf("s%0d_sov_interval", i), sov_int,
                tbl[i].hp * (tbl[i].intl ? tbl[i].nl / 2 : tbl[i].nl));
            chk($sformatf("s%0d_fp_last", i), fp_last, tbl[i].intl);
            chk($sformatf("s%0d_fp_prev", i), fp_prev, 0);
        end

        // Line length 40 -> 50 mid-frame: one falling and one replacing pulse, a line apart.
        run_frames(40, 10, 1'b0, NFRAME, 1);
        base_rc = rc_cnt; base_rcb = rc_cnt_b; base_low = s_low_cnt;
        for (int l = 0; l < 10; l++) run_line((l < 5) ? 40 : 50, l < 2, 1'b0, 1);
        run_frames(50, 10, 1'b0, 3, 1);
        chk("chg_rc_count_a", rc_cnt - base_rc, 2);
        chk("chg_rc_count_b", rc_cnt_b - base_rcb, 2);
        chk("chg_rc_interval", rc_int, 50);
        chk("chg_valid_dropped", s_low_cnt > base_low, 1);
        chk("chg_samples_a", tsc_a, 50);
        chk("chg_lines_valid", tlcv_a, 1);
        chk("chg_stable", stable_a, 1);

        // hsync removed after a complete frame: sample counter saturates near 16383.
        base_rc = rc_cnt;
        for (int c = 0; c < 16250; c++) tick(0, 0, 0, 1);
        chk("loss_before_sat_stable", stable_a, 1);
        for (int c = 0; c < 250; c++) tick(0, 0, 0, 1);
        chk("loss_stable", stable_a, 0);
        chk("loss_samples_valid", tscv_a, 0);
        chk("loss_lines_valid", tlcv_a, 1);
        chk("loss_rc_count", rc_cnt - base_rc, 1);
        base_rc = rc_cnt;
        run_line(50, 1'b1, 1'b0, 1);
        run_line(50, 1'b1, 1'b0, 1);
        chk("restore_not_yet_valid", tscv_a, 0);
        run_line(50, 1'b0, 1'b0, 1);
        chk("restore_valid", tscv_a, 1);
        chk("restore_stable", stable_a, 1);
        for (int l = 3; l < 10; l++) run_line(50, 1'b0, 1'b0, 1);
        chk("restore_rc_none", rc_cnt - base_rc, 0);
        chk("restore_samples", tsc_a, 50);

        // One-cycle enable drop mid-line clears everything; requalification restarts.
        for (int c = 0; c < 20; c++) tick(c < 4, 1'b1, 1'b0, 1'b1);
        enable = 1'b0;
        tick(0, 0, 0, 1);
        chk("enable_clear_a", outs_a(), 0);
        chk("enable_clear_b", outs_b(), 0);
        enable = 1'b1;
        for (int c = 0; c < 30; c++) tick(0, 0, 0, 1);
        run_line(50, 1'b1, 1'b0, 1);
        run_line(50, 1'b1, 1'b0, 1);
        chk("enable_requal_pending", tscv_a, 0);
        run_line(50, 1'b0, 1'b0, 1);
        chk("enable_requal_valid", tscv_a, 1);
        for (int l = 3; l < 10; l++) run_line(50, 1'b0, 1'b0, 1);
        run_frames(50, 10, 1'b0, 3, 1);
        chk("enable_restable", stable_a, 1);
        chk("enable_lines_b", tlc_b, 9);

        // Asynchronous reset mid-line takes effect before the next clock edge.
        for (int c = 0; c < 20; c++) tick(c < 4, 1'b0, 1'b0, 1'b1);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_a", outs_a(), 0);
        chk("async_rst_b", outs_b(), 0);
        @(posedge clk); #1;
        tick(0, 0, 0, 1);
        rst = 1'b1;
        run_frames(36, 12, 1'b0, 4, 1);
        chk("rst_samples_a", tsc_a, 36);
        chk("rst_lines_a", tlc_a, 12);
        chk("rst_stable", stable_a, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
